// File: rtl/idex_pkg.sv
// Shared definitions for the ID/EX forwarding pipe: state encoding, NOP word, counter width.
// Latency: n/a (package only).
// Backpressure: n/a. Optional multicycle state is guarded by IDEX_MULTICYCLE_EN.
package idex_pkg;

  localparam int HAZ_CNT_W = 32;

  // addi x0,x0,0 -- what the held IR reads after reset or flush
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

`ifdef IDEX_MULTICYCLE_EN
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/idex_fwd_pipe_if.sv
// Bundle of upstream, forwarding, downstream and status signals of the ID/EX pipe.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides. Multicycle signals exist only with IDEX_MULTICYCLE_EN.
interface idex_fwd_pipe_if
  import idex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int RADDR_W = 5
);
  logic                              id_valid_i;
  logic                              id_ready_o;
  logic [XLEN-1:0]                   id_pc_i;
  logic [XLEN-1:0]                   id_ir_i;
  logic [XLEN-1:0]                   id_rs1_data_i;
  logic [XLEN-1:0]                   id_rs2_data_i;
  logic [XLEN-1:0]                   id_imm_i;
  logic                              id_uses_rs1_i;
  logic                              id_uses_rs2_i;
  logic [NUM_FWD-1:0]                fwd_valid_i;
  logic [NUM_FWD-1:0][RADDR_W-1:0]   fwd_rd_i;
  logic [NUM_FWD-1:0][XLEN-1:0]      fwd_data_i;
  logic [NUM_FWD-1:0]                fwd_avail_i;
  logic                              ex_valid_o;
  logic                              ex_ready_i;
  logic [XLEN-1:0]                   ex_pc_o;
  logic [XLEN-1:0]                   ex_ir_o;
  logic [XLEN-1:0]                   ex_op_a_o;
  logic [XLEN-1:0]                   ex_op_b_o;
  logic [XLEN-1:0]                   ex_imm_o;
  logic                              flush_i;
  logic [HAZ_CNT_W-1:0]              hazard_cycles_o;
`ifdef IDEX_MULTICYCLE_EN
  logic                              id_is_mc_i;
  logic                              mc_start_o;
  logic                              mc_done_i;
`endif

  // Environment side: drives instructions, forwarding state and the downstream ready
  modport master (
`ifdef IDEX_MULTICYCLE_EN
    output id_is_mc_i, mc_done_i,
    input  mc_start_o,
`endif
    output id_valid_i, id_pc_i, id_ir_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
    output id_uses_rs1_i, id_uses_rs2_i,
    output fwd_valid_i, fwd_rd_i, fwd_data_i, fwd_avail_i,
    output ex_ready_i, flush_i,
    input  id_ready_o, ex_valid_o, ex_pc_o, ex_ir_o, ex_op_a_o, ex_op_b_o, ex_imm_o,
    input  hazard_cycles_o
  );

  // Pipe side
  modport slave (
`ifdef IDEX_MULTICYCLE_EN
    input  id_is_mc_i, mc_done_i,
    output mc_start_o,
`endif
    input  id_valid_i, id_pc_i, id_ir_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
    input  id_uses_rs1_i, id_uses_rs2_i,
    input  fwd_valid_i, fwd_rd_i, fwd_data_i, fwd_avail_i,
    input  ex_ready_i, flush_i,
    output id_ready_o, ex_valid_o, ex_pc_o, ex_ir_o, ex_op_a_o, ex_op_b_o, ex_imm_o,
    output hazard_cycles_o
  );

endinterface

// File: rtl/fwd_select.sv
// Resolves one source operand against the forwarding sources; index 0 is youngest and wins.
// Latency: combinational.
// Backpressure: flags hazard when the winning source has not produced its result yet.
module fwd_select #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int RADDR_W = 5
) (
  input  logic                            uses,
  input  logic [RADDR_W-1:0]              rs,
  input  logic [XLEN-1:0]                 held,
  input  logic [NUM_FWD-1:0]              fwd_valid,
  input  logic [NUM_FWD-1:0][RADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]    fwd_data,
  input  logic [NUM_FWD-1:0]              fwd_avail,
  output logic [XLEN-1:0]                 data,
  output logic                            hazard
);

  logic found;

  // Priority search, youngest first; x0 is hardwired zero and never forwarded
  always_comb begin
    data   = held;
    hazard = 1'b0;
    found  = 1'b0;
    if (uses) begin
      if (rs == '0) begin
        data = '0;
      end else begin
        for (int i = 0; i < NUM_FWD; i++) begin
          if (!found && fwd_valid[i] && (fwd_rd[i] == rs)) begin
            found  = 1'b1;
            data   = fwd_data[i];
            hazard = !fwd_avail[i];
          end
        end
      end
    end
  end

endmodule

// File: rtl/idex_fwd_pipe.sv
// One-entry ID/EX register with operand forwarding, load-use interlock and hazard counter.
// Latency: 1 cycle capture-to-issue; back-to-back issue with no bubble when downstream is ready.
// Backpressure: id_ready_o drops while the entry is held; IDEX_MULTICYCLE_EN adds a multicycle wait state.
module idex_fwd_pipe
  import idex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int RADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  idex_fwd_pipe_if.slave bus
);

  state_t               state;
  logic [XLEN-1:0]      pc_q, ir_q, a_q, b_q, imm_q;
  logic                 uses1_q, uses2_q;
  logic [XLEN-1:0]      res_a, res_b;
  logic                 haz_a, haz_b;
  logic                 full, hazard, ex_valid, handoff, id_ready, capture;
  logic [HAZ_CNT_W-1:0] haz_cnt;
`ifdef IDEX_MULTICYCLE_EN
  logic                 is_mc_q, mc_done_q, mc_start_q;
`endif

  fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RADDR_W(RADDR_W)) u_sel_a (
    .uses      (uses1_q),
    .rs        (ir_q[15 +: RADDR_W]),
    .held      (a_q),
    .fwd_valid (bus.fwd_valid_i),
    .fwd_rd    (bus.fwd_rd_i),
    .fwd_data  (bus.fwd_data_i),
    .fwd_avail (bus.fwd_avail_i),
    .data      (res_a),
    .hazard    (haz_a)
  );

  fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RADDR_W(RADDR_W)) u_sel_b (
    .uses      (uses2_q),
    .rs        (ir_q[20 +: RADDR_W]),
    .held      (b_q),
    .fwd_valid (bus.fwd_valid_i),
    .fwd_rd    (bus.fwd_rd_i),
    .fwd_data  (bus.fwd_data_i),
    .fwd_avail (bus.fwd_avail_i),
    .data      (res_b),
    .hazard    (haz_b)
  );

  // Handshake decode; a multicycle entry is only issuable once its unit reports done
  assign full   = (state == ST_FULL);
  assign hazard = full && (haz_a || haz_b);
`ifdef IDEX_MULTICYCLE_EN
  assign ex_valid = full && !hazard && (!is_mc_q || mc_done_q);
`else
  assign ex_valid = full && !hazard;
`endif
  assign handoff  = ex_valid && bus.ex_ready_i;
  assign id_ready = (state == ST_EMPTY) || handoff;
  assign capture  = bus.id_valid_i && id_ready && !bus.flush_i;

  assign bus.id_ready_o      = id_ready;
  assign bus.ex_valid_o      = ex_valid;
  assign bus.ex_pc_o         = pc_q;
  assign bus.ex_ir_o         = ir_q;
  assign bus.ex_op_a_o       = res_a;
  assign bus.ex_op_b_o       = res_b;
  assign bus.ex_imm_o        = imm_q;
  assign bus.hazard_cycles_o = haz_cnt;
`ifdef IDEX_MULTICYCLE_EN
  assign bus.mc_start_o      = mc_start_q;
`endif

  // Entry state machine: flush beats capture beats hand-off; a held entry keeps refreshing
  // its operands so forwarded data outlives the producing stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_EMPTY;
      pc_q    <= '0;
      ir_q    <= XLEN'(NOP_INSN);
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      uses1_q <= 1'b0;
      uses2_q <= 1'b0;
`ifdef IDEX_MULTICYCLE_EN
      is_mc_q    <= 1'b0;
      mc_done_q  <= 1'b0;
      mc_start_q <= 1'b0;
`endif
    end else begin
`ifdef IDEX_MULTICYCLE_EN
      mc_start_q <= 1'b0;
`endif
      if (bus.flush_i) begin
        state   <= ST_EMPTY;
        ir_q    <= XLEN'(NOP_INSN);
        uses1_q <= 1'b0;
        uses2_q <= 1'b0;
`ifdef IDEX_MULTICYCLE_EN
        is_mc_q   <= 1'b0;
        mc_done_q <= 1'b0;
`endif
      end else if (capture) begin
        state   <= ST_FULL;
        pc_q    <= bus.id_pc_i;
        ir_q    <= bus.id_ir_i;
        a_q     <= bus.id_rs1_data_i;
        b_q     <= bus.id_rs2_data_i;
        imm_q   <= bus.id_imm_i;
        uses1_q <= bus.id_uses_rs1_i;
        uses2_q <= bus.id_uses_rs2_i;
`ifdef IDEX_MULTICYCLE_EN
        is_mc_q   <= bus.id_is_mc_i;
        mc_done_q <= 1'b0;
`endif
      end else if (handoff) begin
        state <= ST_EMPTY;
      end else if (state != ST_EMPTY) begin
        // an operand still waiting on its producer keeps its old held value
        a_q <= haz_a ? a_q : res_a;
        b_q <= haz_b ? b_q : res_b;
`ifdef IDEX_MULTICYCLE_EN
        if (full && is_mc_q && !mc_done_q && !hazard) begin
          state      <= ST_MC_WAIT;
          mc_start_q <= 1'b1;
        end else if ((state == ST_MC_WAIT) && bus.mc_done_i) begin
          state     <= ST_FULL;
          mc_done_q <= 1'b1;
        end
`endif
      end
    end
  end

  // Interlock cycle counter, sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      haz_cnt <= '0;
    end else if (hazard && (haz_cnt != '1)) begin
      haz_cnt <= haz_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_idex_fwd_pipe.sv
// Directed self-checking bench for idex_fwd_pipe; covers reset, forwarding priority, interlock,
// stall stability, flush, uses gating and (with IDEX_MULTICYCLE_EN) the multicycle path.
module tb_idex_fwd_pipe;
  import idex_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  idex_fwd_pipe_if #(.XLEN(32), .NUM_FWD(3), .RADDR_W(5)) bus ();

  idex_fwd_pipe #(.XLEN(32), .NUM_FWD(3), .RADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // add x5,x3,x4 and addi x1,x0,5
  localparam logic [31:0] ADD_X5_X3_X4 = 32'h0041_82B3;
  localparam logic [31:0] ADDI_X1_5    = 32'h0050_0093;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid_i    = 1'b0;
    bus.id_pc_i       = '0;
    bus.id_ir_i       = '0;
    bus.id_rs1_data_i = '0;
    bus.id_rs2_data_i = '0;
    bus.id_imm_i      = '0;
    bus.id_uses_rs1_i = 1'b0;
    bus.id_uses_rs2_i = 1'b0;
    bus.fwd_valid_i   = '0;
    bus.fwd_rd_i      = '0;
    bus.fwd_data_i    = '0;
    bus.fwd_avail_i   = '1;
    bus.ex_ready_i    = 1'b0;
    bus.flush_i       = 1'b0;
`ifdef IDEX_MULTICYCLE_EN
    bus.id_is_mc_i    = 1'b0;
    bus.mc_done_i     = 1'b0;
`endif
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] imm, input logic u1, input logic u2);
    bus.id_valid_i    = 1'b1;
    bus.id_pc_i       = pc;
    bus.id_ir_i       = ir;
    bus.id_rs1_data_i = d1;
    bus.id_rs2_data_i = d2;
    bus.id_imm_i      = imm;
    bus.id_uses_rs1_i = u1;
    bus.id_uses_rs2_i = u2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.ex_valid_o); end
    checks++; if (bus.ex_ir_o !== 32'h13) begin errors++; $display("FAIL rst_ir: got %h want 00000013", bus.ex_ir_o); end
    checks++; if (bus.ex_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", bus.ex_pc_o); end
    checks++; if (bus.ex_op_a_o !== 32'h0) begin errors++; $display("FAIL rst_op_a: got %h want 0", bus.ex_op_a_o); end
    checks++; if (bus.ex_op_b_o !== 32'h0) begin errors++; $display("FAIL rst_op_b: got %h want 0", bus.ex_op_b_o); end
    checks++; if (bus.ex_imm_o !== 32'h0) begin errors++; $display("FAIL rst_imm: got %h want 0", bus.ex_imm_o); end
    checks++; if (bus.hazard_cycles_o !== 32'h0) begin errors++; $display("FAIL rst_haz: got %0d want 0", bus.hazard_cycles_o); end
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (bus.id_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.id_ready_o); end
  endtask

  task automatic test_capture();
    load(32'h100, ADDI_X1_5, 32'h77, 32'h88, 32'h5, 1'b1, 1'b0);
    step();
    bus.id_valid_i = 1'b0;
    #1;
    checks++; if (bus.ex_valid_o !== 1'b1) begin errors++; $display("FAIL cap_valid: got %b want 1", bus.ex_valid_o); end
    checks++; if (bus.ex_ir_o !== 32'h0050_0093) begin errors++; $display("FAIL cap_ir: got %h want 00500093", bus.ex_ir_o); end
    checks++; if (bus.ex_pc_o !== 32'h100) begin errors++; $display("FAIL cap_pc: got %h want 100", bus.ex_pc_o); end
    checks++; if (bus.ex_op_a_o !== 32'h0) begin errors++; $display("FAIL cap_x0: got %h want 0", bus.ex_op_a_o); end
    checks++; if (bus.ex_imm_o !== 32'h5) begin errors++; $display("FAIL cap_imm: got %h want 5", bus.ex_imm_o); end
    checks++; if (bus.id_ready_o !== 1'b0) begin errors++; $display("FAIL cap_ready_held: got %b want 0", bus.id_ready_o); end
    bus.ex_ready_i = 1'b1;
    #1;
    checks++; if (bus.id_ready_o !== 1'b1) begin errors++; $display("FAIL cap_ready_pass: got %b want 1", bus.id_ready_o); end
    step();
    bus.ex_ready_i = 1'b0;
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL cap_drain: got %b want 0", bus.ex_valid_o); end
  endtask

  task automatic test_priority();
    load(32'h104, ADD_X5_X3_X4, 32'h111, 32'h222, 32'h0, 1'b1, 1'b1);
    step();
    bus.id_valid_i    = 1'b0;
    bus.fwd_valid_i   = 3'b101;
    bus.fwd_rd_i[0]   = 5'd3;
    bus.fwd_rd_i[2]   = 5'd3;
    bus.fwd_data_i[0] = 32'hA;
    bus.fwd_data_i[2] = 32'hC;
    #1;
    checks++; if (bus.ex_op_a_o !== 32'hA) begin errors++; $display("FAIL prio_youngest: got %h want a", bus.ex_op_a_o); end
    checks++; if (bus.ex_op_b_o !== 32'h222) begin errors++; $display("FAIL prio_nomatch_b: got %h want 222", bus.ex_op_b_o); end
    bus.fwd_valid_i = 3'b100;
    #1;
    checks++; if (bus.ex_op_a_o !== 32'hC) begin errors++; $display("FAIL prio_oldest: got %h want c", bus.ex_op_a_o); end
    bus.fwd_valid_i = 3'b000;
    #1;
    checks++; if (bus.ex_op_a_o !== 32'h111) begin errors++; $display("FAIL prio_held: got %h want 111", bus.ex_op_a_o); end
    bus.ex_ready_i = 1'b1;
    step();
    bus.ex_ready_i = 1'b0;
    clear_inputs();
  endtask

  task automatic test_hazard();
    load(32'h108, ADD_X5_X3_X4, 32'h111, 32'h222, 32'h0, 1'b1, 1'b1);
    bus.ex_ready_i = 1'b1;
    step();
    bus.id_valid_i     = 1'b0;
    bus.fwd_valid_i[0] = 1'b1;
    bus.fwd_rd_i[0]    = 5'd3;
    bus.fwd_data_i[0]  = 32'h99;
    bus.fwd_avail_i[0] = 1'b0;
    #1;
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL haz_cycle1: got %b want 0", bus.ex_valid_o); end
    step();
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL haz_cycle2: got %b want 0", bus.ex_valid_o); end
    step();
    bus.fwd_avail_i[0] = 1'b1;
    bus.fwd_data_i[0]  = 32'h55;
    #1;
    checks++; if (bus.ex_valid_o !== 1'b1) begin errors++; $display("FAIL haz_release: got %b want 1", bus.ex_valid_o); end
    checks++; if (bus.ex_op_a_o !== 32'h55) begin errors++; $display("FAIL haz_data: got %h want 55", bus.ex_op_a_o); end
    checks++; if (bus.ex_op_b_o !== 32'h222) begin errors++; $display("FAIL haz_op_b: got %h want 222", bus.ex_op_b_o); end
    checks++; if (bus.hazard_cycles_o !== 32'd2) begin errors++; $display("FAIL haz_count: got %0d want 2", bus.hazard_cycles_o); end
    step();
    bus.ex_ready_i = 1'b0;
    clear_inputs();
  endtask

  task automatic test_stall();
    bus.fwd_valid_i[0] = 1'b1;
    bus.fwd_rd_i[0]    = 5'd3;
    bus.fwd_data_i[0]  = 32'hAB;
    load(32'h10C, ADD_X5_X3_X4, 32'h111, 32'h222, 32'h0, 1'b1, 1'b1);
    step();
    load(32'h200, ADDI_X1_5, 32'h0, 32'h0, 32'h5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.id_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.id_ready_o); end
      checks++; if (bus.ex_pc_o !== 32'h10C) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 10c", i, bus.ex_pc_o); end
      checks++; if (bus.ex_ir_o !== ADD_X5_X3_X4) begin errors++; $display("FAIL stall_ir[%0d]: got %h want 004182b3", i, bus.ex_ir_o); end
      checks++; if (bus.ex_op_a_o !== 32'hAB) begin errors++; $display("FAIL stall_op_a[%0d]: got %h want ab", i, bus.ex_op_a_o); end
      step();
      if (i == 0) bus.fwd_valid_i = '0;
    end
    bus.ex_ready_i = 1'b1;
    #1;
    checks++; if (bus.id_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", bus.id_ready_o); end
    step();
    bus.id_valid_i = 1'b0;
    #1;
    checks++; if (bus.ex_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", bus.ex_valid_o); end
    checks++; if (bus.ex_pc_o !== 32'h200) begin errors++; $display("FAIL b2b_pc: got %h want 200", bus.ex_pc_o); end
    checks++; if (bus.ex_ir_o !== ADDI_X1_5) begin errors++; $display("FAIL b2b_ir: got %h want 00500093", bus.ex_ir_o); end
    step();
    bus.ex_ready_i = 1'b0;
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", bus.ex_valid_o); end
    clear_inputs();
  endtask

  task automatic test_flush();
    load(32'h300, ADD_X5_X3_X4, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1);
    step();
    load(32'h304, ADDI_X1_5, 32'h0, 32'h0, 32'h5, 1'b1, 1'b0);
    bus.ex_ready_i = 1'b1;
    bus.flush_i    = 1'b1;
    step();
    clear_inputs();
    #1;
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.ex_valid_o); end
    checks++; if (bus.ex_ir_o !== 32'h13) begin errors++; $display("FAIL flush_ir: got %h want 00000013", bus.ex_ir_o); end
    checks++; if (bus.id_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus.id_ready_o); end
    step();
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL flush_noleak: got %b want 0", bus.ex_valid_o); end
  endtask

  task automatic test_uses();
    bus.fwd_valid_i[0] = 1'b1;
    bus.fwd_rd_i[0]    = 5'd3;
    bus.fwd_data_i[0]  = 32'hDEAD;
    bus.fwd_avail_i[0] = 1'b0;
    load(32'h400, ADD_X5_X3_X4, 32'h333, 32'h444, 32'h0, 1'b0, 1'b1);
    step();
    bus.id_valid_i = 1'b0;
    #1;
    checks++; if (bus.ex_valid_o !== 1'b1) begin errors++; $display("FAIL uses_nohaz: got %b want 1", bus.ex_valid_o); end
    checks++; if (bus.ex_op_a_o !== 32'h333) begin errors++; $display("FAIL uses_held: got %h want 333", bus.ex_op_a_o); end
    bus.ex_ready_i = 1'b1;
    step();
    bus.ex_ready_i     = 1'b0;
    bus.fwd_rd_i[0]    = 5'd0;
    bus.fwd_data_i[0]  = 32'hF;
    load(32'h404, ADDI_X1_5, 32'h77, 32'h0, 32'h5, 1'b1, 1'b0);
    step();
    bus.id_valid_i = 1'b0;
    #1;
    checks++; if (bus.ex_valid_o !== 1'b1) begin errors++; $display("FAIL x0_nohaz: got %b want 1", bus.ex_valid_o); end
    checks++; if (bus.ex_op_a_o !== 32'h0) begin errors++; $display("FAIL x0_zero: got %h want 0", bus.ex_op_a_o); end
    checks++; if (bus.hazard_cycles_o !== 32'd2) begin errors++; $display("FAIL uses_count: got %0d want 2", bus.hazard_cycles_o); end
    bus.ex_ready_i = 1'b1;
    step();
    clear_inputs();
  endtask

`ifdef IDEX_MULTICYCLE_EN
  task automatic test_multicycle();
    int starts;
    starts = 0;
    load(32'h500, ADDI_X1_5, 32'h0, 32'h0, 32'h5, 1'b1, 1'b0);
    bus.id_is_mc_i = 1'b1;
    bus.ex_ready_i = 1'b1;
    step();
    bus.id_valid_i = 1'b0;
    bus.id_is_mc_i = 1'b0;
    #1;
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL mc_prestart: got %b want 0", bus.ex_valid_o); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.mc_start_o === 1'b1) starts++;
      checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL mc_wait[%0d]: got %b want 0", i, bus.ex_valid_o); end
    end
    bus.mc_done_i = 1'b1;
    step();
    bus.mc_done_i = 1'b0;
    if (bus.mc_start_o === 1'b1) starts++;
    checks++; if (bus.ex_valid_o !== 1'b1) begin errors++; $display("FAIL mc_issue: got %b want 1", bus.ex_valid_o); end
    checks++; if (starts !== 1) begin errors++; $display("FAIL mc_pulses: got %0d want 1", starts); end
    step();
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL mc_drain: got %b want 0", bus.ex_valid_o); end
    load(32'h504, ADDI_X1_5, 32'h0, 32'h0, 32'h5, 1'b1, 1'b0);
    bus.id_is_mc_i = 1'b1;
    step();
    bus.id_valid_i = 1'b0;
    bus.id_is_mc_i = 1'b0;
    step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i   = 1'b0;
    bus.mc_done_i = 1'b1;
    step();
    bus.mc_done_i = 1'b0;
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL mc_flush_valid: got %b want 0", bus.ex_valid_o); end
    checks++; if (bus.id_ready_o !== 1'b1) begin errors++; $display("FAIL mc_flush_ready: got %b want 1", bus.id_ready_o); end
    clear_inputs();
  endtask
`endif

  task automatic test_reset_mid();
    load(32'h600, ADD_X5_X3_X4, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1);
    step();
    bus.id_valid_i = 1'b0;
    #1;
    checks++; if (bus.ex_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b want 1", bus.ex_valid_o); end
    rst = 1'b1;
    #1;
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", bus.ex_valid_o); end
    checks++; if (bus.hazard_cycles_o !== 32'h0) begin errors++; $display("FAIL mid_count: got %0d want 0", bus.hazard_cycles_o); end
    checks++; if (bus.ex_ir_o !== 32'h13) begin errors++; $display("FAIL mid_ir: got %h want 00000013", bus.ex_ir_o); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (bus.id_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", bus.id_ready_o); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_capture();
    test_priority();
    test_hazard();
    test_stall();
    test_flush();
    test_uses();
`ifdef IDEX_MULTICYCLE_EN
    test_multicycle();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idex_fwd_pipe.md
IDEX_FWD_PIPE -- requirements
Module: idex_fwd_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/PC/IR data width.
REQ-002 SHALL have parameter NUM_FWD, default 3: number of forwarding sources, index 0 youngest.
REQ-003 SHALL have parameter RADDR_W, default 5: register address width.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports id_valid_i in 1 / id_ready_o out 1: upstream handshake.
REQ-007 SHALL have ports id_pc_i, id_ir_i, id_rs1_data_i, id_rs2_data_i, id_imm_i  input  XLEN each: decoded instruction payload.
REQ-008 SHALL have ports id_uses_rs1_i, id_uses_rs2_i  input  1: operand actually read.
REQ-009 SHALL have ports fwd_valid_i in NUM_FWD, fwd_rd_i in NUM_FWD x RADDR_W, fwd_data_i in NUM_FWD x XLEN, fwd_avail_i in NUM_FWD: forwarding sources; avail=0 means result not yet produced (e.g. load).
REQ-010 SHALL have ports ex_valid_o out 1 / ex_ready_i in 1: downstream handshake.
REQ-011 SHALL have ports ex_pc_o, ex_ir_o, ex_op_a_o, ex_op_b_o, ex_imm_o  output  XLEN: issued instruction with resolved operands.
REQ-012 SHALL have port flush_i  input  1: kill held and incoming instruction.
REQ-013 SHALL have port hazard_cycles_o  output  32: saturating count of interlock cycles.

Function
REQ-014 SHALL hold one entry; states EMPTY, FULL (plus MC_WAIT per REQ-030).
REQ-015 SHALL drive id_ready_o = (state==EMPTY) || (ex_valid_o && ex_ready_i), combinationally.
REQ-016 SHALL capture payload when id_valid_i && id_ready_o && !flush_i; EMPTY->FULL; latency 1 cycle to ex_valid_o.
REQ-017 SHALL leave FULL->EMPTY on ex_valid_o && ex_ready_i without new capture; with capture, stay FULL (back-to-back, no bubble).
REQ-018 SHALL resolve each used operand against sources 0..NUM_FWD-1: first index with fwd_valid_i=1 and fwd_rd_i==rs (from held IR) wins; no match selects held register value.
REQ-019 SHALL never match rs==0; operand x0 always reads zero.
REQ-020 SHALL assert hazard when the winning source has fwd_avail_i=0; ex_valid_o = FULL && !hazard.
REQ-021 SHALL, each cycle the entry is held (FULL and not handed off), re-latch resolved operands into held register values so forwarded data survives source retirement.
REQ-022 SHALL ignore fwd matches for operands whose uses flag is 0.
REQ-023 SHALL on flush_i go to EMPTY next cycle, drop any capture, set held IR to NOP 0x00000013; flush beats all other events.
REQ-024 SHALL increment hazard_cycles_o each cycle FULL && hazard, saturating at 0xFFFFFFFF.
REQ-025 SHALL keep ex_* payload stable while ex_valid_o && !ex_ready_i.

Reset
REQ-026 SHALL on rst asynchronously set state EMPTY, ex_valid_o 0, ex_ir_o 0x00000013, ex_pc_o/op_a/op_b/imm 0, hazard_cycles_o 0.
REQ-027 SHALL, if rst asserts mid-operation (including MC_WAIT), discard the entry with no further handshake.
REQ-028 SHALL present id_ready_o=1 in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL gate multicycle support with macro IDEX_MULTICYCLE_EN.
REQ-030 With IDEX_MULTICYCLE_EN: ports id_is_mc_i in 1, mc_start_o out 1, mc_done_i in 1; FULL entry with is_mc and no hazard pulses mc_start_o one cycle, enters MC_WAIT; ex_valid_o=0 in MC_WAIT; mc_done_i returns to FULL with mc-done flag set, then ex_valid_o=1; flush in MC_WAIT -> EMPTY, late mc_done_i ignored.
REQ-031 Without IDEX_MULTICYCLE_EN: those ports absent, MC_WAIT absent, all entries single-cycle.

Structure
REQ-032 SHALL place state enum, NOP constant and counter width in a shared package idex_pkg.
REQ-033 SHALL implement operand resolution in one sub-module fwd_select, instantiated per operand.

Verification
REQ-034 Reset then id_valid_i=1, IR addi x1,x0,5 -> ex_valid_o=1 next cycle, ex_ir_o=0x00500093.
REQ-035 Held rs1=x3, fwd[0] and fwd[2] rd=3 data 0xA/0xC, both avail -> ex_op_a_o=0xA.
REQ-036 fwd[0] rd=3 avail=0 for 2 cycles then avail=1 data 0x55 -> ex_valid_o low 2 cycles, then 0x55; hazard_cycles_o=2.
REQ-037 ex_ready_i=0 for 3 cycles with id_valid_i=1 -> id_ready_o=0, ex_* stable; source retires meanwhile, operand unchanged.
REQ-038 flush_i same cycle as capture and ex_ready_i=1 -> next cycle EMPTY, ex_valid_o=0, ex_ir_o=0x00000013.
REQ-039 (IDEX_MULTICYCLE_EN) is_mc entry, mc_done_i after 4 cycles -> one mc_start_o pulse, ex_valid_o=1 the cycle after mc_done_i.
